pc_fetch_queue: RTL and testbench



---
 rtl/pc_fetch_queue_pkg.sv | 24 ++
 rtl/pc_fetch_queue_if.sv | 35 +++
 rtl/pc_fetch_queue_fifo.sv | 66 ++++++
 rtl/pc_fetch_queue.sv | 136 +++++++++++++
 tb/tb_pc_fetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_queue_pkg.sv
// rtl/pc_fetch_queue_pkg.sv - shared types and defaults for the bc6502 prefetch queue
// Contents: package pc_fetch_pkg
//   fetch_state_t  - prefetch FSM states (HALT, IDLE, BUS, DRAIN)
//   PC_ABW         - default address bus width
//   PC_DEPTH       - default queue depth in bytes
//   fetch_entry_t  - queue entry {addr, data} at the default address width
package pc_fetch_pkg;

    localparam int PC_ABW   = 24;
    localparam int PC_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUS   = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_ABW-1:0] addr;
        logic [7:0]        data;
    } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_queue_if.sv
// rtl/pc_fetch_queue_if.sv - decoder and bus signals of the prefetch queue
// Signals:
//   ld_i, ld_addr_i          - redirect to a new fetch address (flushes queue)
//   rd_i                     - decoder consumes head byte
//   valid_o, byte_o, pc_o    - head byte, its address (fetch address when empty)
//   cyc_o, stb_o, adr_o      - single-byte bus read request
//   ack_i, dat_i             - bus acknowledge and read data
// Modports: slave = prefetch unit, master = surrounding core / bus
interface pc_fetch_queue_if
    import pc_fetch_pkg::*;
#(
    parameter int ABW = PC_ABW
);
    logic           ld_i;
    logic [ABW-1:0] ld_addr_i;
    logic           rd_i;
    logic           valid_o;
    logic [7:0]     byte_o;
    logic [ABW-1:0] pc_o;
    logic           cyc_o;
    logic           stb_o;
    logic [ABW-1:0] adr_o;
    logic           ack_i;
    logic [7:0]     dat_i;

    modport slave (
        input  ld_i, ld_addr_i, rd_i, ack_i, dat_i,
        output valid_o, byte_o, pc_o, cyc_o, stb_o, adr_o
    );

    modport master (
        output ld_i, ld_addr_i, rd_i, ack_i, dat_i,
        input  valid_o, byte_o, pc_o, cyc_o, stb_o, adr_o
    );
endinterface

// File: rtl/pc_fetch_queue_fifo.sv
// rtl/pc_fetch_queue_fifo.sv - DEPTH-entry synchronous FIFO holding tagged fetch bytes
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   i_push, i_data  - write one entry
//   i_pop           - drop the head entry (ignored when empty)
//   i_flush         - empty the FIFO; overrides push and pop
//   o_count         - number of stored entries (0..DEPTH)
//   o_head          - head entry (meaningful only when o_empty is low)
//   o_empty         - no entries stored
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output logic [W-1:0]  o_head,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_push  = i_push & ((r_count != FULL_CNT) | w_pop) & ~i_flush;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/pc_fetch_queue.sv
// rtl/pc_fetch_queue.sv - bc6502 instruction prefetch unit (FSM, fetch address, bus master)
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   bus           - pc_fetch_queue_if.slave (decoder side and byte-wide bus read port)
// Parameters: ABW address width, DEPTH queue depth (power of two, 2..16)
// Build option: PC_BANK_WRAP_EN - fetch address increments only bits [15:0]
//               (program-bank wrap); otherwise the full ABW address increments.
module pc_fetch_queue
    import pc_fetch_pkg::*;
#(
    parameter int ABW   = PC_ABW,
    parameter int DEPTH = PC_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    pc_fetch_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [ABW-1:0] addr;
        logic [7:0]     data;
    } q_entry_t;

    fetch_state_t   r_state;
    logic [ABW-1:0] r_fa;
    logic [ABW-1:0] r_adr;
    logic           r_cyc;

    logic [ABW-1:0] w_fa_inc;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_post;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    q_entry_t       w_push_entry;
    q_entry_t       w_head;

`ifdef PC_BANK_WRAP_EN
    assign w_fa_inc = {r_fa[ABW-1:16], r_fa[15:0] + 16'd1};
`else
    assign w_fa_inc = r_fa + {{(ABW-1){1'b0}}, 1'b1};
`endif

    // A load discards whatever the bus returns this cycle and anything queued.
    assign w_push = (r_state == ST_BUS) & bus.ack_i & ~bus.ld_i;
    assign w_pop  = bus.rd_i & ~w_empty & ~bus.ld_i;

    // Occupancy after this cycle's ack push and decoder pop; decides whether the
    // next read may be issued back to back.
    assign w_count_post = w_count + {{(CW-1){1'b0}}, 1'b1} - {{(CW-1){1'b0}}, w_pop};

    assign w_push_entry = '{addr: r_fa, data: bus.dat_i};

    fetch_fifo #(
        .W     ($bits(q_entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.ld_i),
        .o_count (w_count),
        .o_head  (w_head),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_HALT;
            r_fa    <= '0;
            r_adr   <= '0;
            r_cyc   <= 1'b0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (bus.ld_i) begin
                        r_fa    <= bus.ld_addr_i;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.ld_i) begin
                        r_fa <= bus.ld_addr_i;
                    end else if (w_count < FULL_CNT) begin
                        r_adr   <= r_fa;
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus.ld_i) begin
                        r_fa <= bus.ld_addr_i;
                        if (bus.ack_i) begin
                            r_cyc   <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            // The outstanding read must complete before a new one.
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.ack_i) begin
                        r_fa <= w_fa_inc;
                        if (w_count_post < FULL_CNT) begin
                            r_adr <= w_fa_inc;
                        end else begin
                            r_cyc   <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.ld_i) r_fa <= bus.ld_addr_i;
                    if (bus.ack_i) begin
                        r_cyc   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.cyc_o   = r_cyc;
    assign bus.stb_o   = r_cyc;
    assign bus.adr_o   = r_adr;
    assign bus.valid_o = ~w_empty;
    assign bus.byte_o  = w_empty ? 8'h00 : w_head.data;
    assign bus.pc_o    = w_empty ? r_fa : w_head.addr;
endmodule

// File: tb/tb_pc_fetch_queue.sv
// tb/tb_pc_fetch_queue.sv - directed self-checking bench for pc_fetch_queue
module tb_pc_fetch_queue;
    localparam int ABW = 24;

`ifdef PC_BANK_WRAP_EN
    localparam logic [ABW-1:0] A2 = 24'h000000;
    localparam logic [ABW-1:0] A3 = 24'h000001;
    localparam logic [ABW-1:0] A4 = 24'h000002;
    localparam logic [ABW-1:0] A5 = 24'h000003;
`else
    localparam logic [ABW-1:0] A2 = 24'h010000;
    localparam logic [ABW-1:0] A3 = 24'h010001;
    localparam logic [ABW-1:0] A4 = 24'h010002;
    localparam logic [ABW-1:0] A5 = 24'h010003;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    pc_fetch_queue_if #(.ABW(ABW)) bus();

    logic       r_auto_ack  = 1'b0;
    logic       r_ack_force = 1'b0;
    logic       r_use_tab   = 1'b0;
    logic [7:0] tab [4];

    assign bus.ack_i = (r_auto_ack & bus.stb_o) | r_ack_force;
    assign bus.dat_i = r_use_tab ? tab[bus.adr_o[1:0]] : (bus.adr_o[7:0] ^ 8'h5A);

    pc_fetch_queue #(.ABW(ABW), .DEPTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic do_reset();
        bus.ld_i = 1'b0; bus.rd_i = 1'b0; bus.ld_addr_i = '0;
        r_auto_ack = 1'b0; r_ack_force = 1'b0; r_use_tab = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic load(input logic [ABW-1:0] a);
        bus.ld_i = 1'b1; bus.ld_addr_i = a;
        @(negedge clk_i);
        bus.ld_i = 1'b0;
    endtask

    task automatic wait_stb(output bit ok);
        int k;
        k = 0;
        while (!bus.stb_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        ok = bus.stb_o;
    endtask

    task automatic ack_once();
        r_ack_force = 1'b1;
        @(negedge clk_i);
        r_ack_force = 1'b0;
    endtask

    task automatic pop_once();
        bus.rd_i = 1'b1;
        @(negedge clk_i);
        bus.rd_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (bus.cyc_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.pc_o !== 24'h0) begin
                n_err++;
                $display("FAIL reset_idle c=%0d: cyc=%b valid=%b pc=%h required 0/0/000000",
                         c, bus.cyc_o, bus.valid_o, bus.pc_o);
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (bus.adr_o !== 24'h0 || bus.byte_o !== 8'h00 || bus.stb_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_bus: adr=%h byte=%h stb=%b required 000000/00/0",
                     bus.adr_o, bus.byte_o, bus.stb_o);
        end
    endtask

    task automatic test_wrap_fill();
        logic [ABW-1:0] seen [8];
        logic [ABW-1:0] exp_a [4];
        int nacks, first_c, last_c;
        exp_a[0] = 24'h00FFFE; exp_a[1] = 24'h00FFFF; exp_a[2] = A2; exp_a[3] = A3;
        do_reset();
        tab[0] = 8'h34; tab[1] = 8'h56; tab[2] = 8'hA9; tab[3] = 8'h12;
        r_use_tab = 1'b1; r_auto_ack = 1'b1;
        load(24'h00FFFE);
        nacks = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.stb_o && bus.ack_i) begin
                if (nacks < 8) seen[nacks] = bus.adr_o;
                if (nacks == 0) first_c = c;
                last_c = c;
                nacks++;
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (nacks !== 4) begin
            n_err++;
            $display("FAIL fill_acks: got %0d acks required 4", nacks);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < nacks) begin
                n_cmp++;
                if (seen[i] !== exp_a[i]) begin
                    n_err++;
                    $display("FAIL wrap_adr[%0d]: adr=%h required %h", i, seen[i], exp_a[i]);
                end
            end
        end
        n_cmp++;
        if (last_c - first_c !== 3) begin
            n_err++;
            $display("FAIL zero_wait: span=%0d cycles required 3", last_c - first_c);
        end
        n_cmp++;
        if (bus.cyc_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.byte_o !== 8'hA9 ||
            bus.pc_o !== 24'h00FFFE) begin
            n_err++;
            $display("FAIL full_head: cyc=%b valid=%b byte=%h pc=%h required 0/1/A9/00FFFE",
                     bus.cyc_o, bus.valid_o, bus.byte_o, bus.pc_o);
        end
        pop_once();
        n_cmp++;
        if (bus.byte_o !== 8'h12 || bus.pc_o !== 24'h00FFFF) begin
            n_err++;
            $display("FAIL pop1: byte=%h pc=%h required 12/00FFFF", bus.byte_o, bus.pc_o);
        end
        nacks = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.stb_o && bus.ack_i) begin
                if (nacks < 8) seen[nacks] = bus.adr_o;
                nacks++;
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (nacks !== 1) begin
            n_err++;
            $display("FAIL refill_acks: got %0d acks required 1", nacks);
        end else begin
            n_cmp++;
            if (seen[0] !== A4) begin
                n_err++;
                $display("FAIL refill_adr: adr=%h required %h", seen[0], A4);
            end
        end
        r_auto_ack = 1'b0;
        pop_once();
        n_cmp++;
        if (bus.byte_o !== 8'h34 || bus.pc_o !== A2) begin
            n_err++;
            $display("FAIL pop2: byte=%h pc=%h required 34/%h", bus.byte_o, bus.pc_o, A2);
        end
        pop_once();
        n_cmp++;
        if (bus.byte_o !== 8'h56 || bus.pc_o !== A3) begin
            n_err++;
            $display("FAIL pop3: byte=%h pc=%h required 56/%h", bus.byte_o, bus.pc_o, A3);
        end
        pop_once();
        n_cmp++;
        if (bus.byte_o !== 8'hA9 || bus.pc_o !== A4) begin
            n_err++;
            $display("FAIL pop4: byte=%h pc=%h required A9/%h", bus.byte_o, bus.pc_o, A4);
        end
        pop_once();
        n_cmp++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== A5) begin
            n_err++;
            $display("FAIL pop_empty: valid=%b pc=%h required 0/%h", bus.valid_o, bus.pc_o, A5);
        end
    endtask

    task automatic test_drain();
        bit ok;
        do_reset();
        load(24'h001003);
        wait_stb(ok);
        n_cmp++;
        if (!ok || bus.adr_o !== 24'h001003) begin
            n_err++;
            $display("FAIL drain_req: stb=%b adr=%h required 1/001003", bus.stb_o, bus.adr_o);
        end
        load(24'h002000);
        n_cmp++;
        if (bus.cyc_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drain_hold1: cyc=%b valid=%b required 1/0", bus.cyc_o, bus.valid_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (bus.cyc_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drain_hold2: cyc=%b valid=%b required 1/0", bus.cyc_o, bus.valid_o);
        end
        ack_once();
        n_cmp++;
        if (bus.cyc_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drain_discard: cyc=%b valid=%b required 0/0", bus.cyc_o, bus.valid_o);
        end
        wait_stb(ok);
        n_cmp++;
        if (!ok || bus.adr_o !== 24'h002000) begin
            n_err++;
            $display("FAIL drain_next_req: stb=%b adr=%h required 1/002000", bus.stb_o, bus.adr_o);
        end
        ack_once();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.byte_o !== 8'h5A || bus.pc_o !== 24'h002000) begin
            n_err++;
            $display("FAIL drain_new_head: valid=%b byte=%h pc=%h required 1/5A/002000",
                     bus.valid_o, bus.byte_o, bus.pc_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        load(24'h003000);
        wait_stb(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_req: stb=%b required 1", bus.stb_o);
        end
        ack_once();
        ack_once();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 24'h003000 || bus.byte_o !== 8'h5A) begin
            n_err++;
            $display("FAIL b2b_head0: valid=%b pc=%h byte=%h required 1/003000/5A",
                     bus.valid_o, bus.pc_o, bus.byte_o);
        end
        bus.rd_i = 1'b1; r_ack_force = 1'b1;
        @(negedge clk_i);
        bus.rd_i = 1'b0; r_ack_force = 1'b0;
        n_cmp++;
        if (bus.pc_o !== 24'h003001 || bus.byte_o !== 8'h5B || bus.stb_o !== 1'b1 ||
            bus.adr_o !== 24'h003003) begin
            n_err++;
            $display("FAIL b2b_simul: pc=%h byte=%h stb=%b adr=%h required 003001/5B/1/003003",
                     bus.pc_o, bus.byte_o, bus.stb_o, bus.adr_o);
        end
        pop_once();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 24'h003002 || bus.byte_o !== 8'h58) begin
            n_err++;
            $display("FAIL b2b_pop2: valid=%b pc=%h byte=%h required 1/003002/58",
                     bus.valid_o, bus.pc_o, bus.byte_o);
        end
        pop_once();
        n_cmp++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 24'h003003) begin
            n_err++;
            $display("FAIL b2b_empty: valid=%b pc=%h required 0/003003", bus.valid_o, bus.pc_o);
        end
    endtask

    task automatic test_rd_empty();
        pop_once();
        n_cmp++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 24'h003003 || bus.cyc_o !== 1'b1 ||
            bus.adr_o !== 24'h003003 || bus.byte_o !== 8'h00) begin
            n_err++;
            $display("FAIL rd_empty: valid=%b pc=%h cyc=%b adr=%h byte=%h required 0/003003/1/003003/00",
                     bus.valid_o, bus.pc_o, bus.cyc_o, bus.adr_o, bus.byte_o);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: cyc=%b stb=%b valid=%b required 0/0/0",
                     bus.cyc_o, bus.stb_o, bus.valid_o);
        end
        r_ack_force = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        r_ack_force = 1'b0;
        n_cmp++;
        if (bus.cyc_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.pc_o !== 24'h0) begin
            n_err++;
            $display("FAIL late_ack: cyc=%b valid=%b pc=%h required 0/0/000000",
                     bus.cyc_o, bus.valid_o, bus.pc_o);
        end
    endtask

    initial begin
        bus.ld_i = 1'b0; bus.rd_i = 1'b0; bus.ld_addr_i = '0;
        tab[0] = 8'h00; tab[1] = 8'h00; tab[2] = 8'h00; tab[3] = 8'h00;
        @(negedge clk_i);
        test_reset();
        test_wrap_fill();
        test_drain();
        test_back_to_back();
        test_rd_empty();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
